// File: rtl/core_regfile_sb.sv
// Register file with x0 hardwired to zero, optional write-to-read forwarding,
// a pending-write scoreboard and a sequential zeroing sweep.

module core_regfile_sb_rdport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  logic [AW-1:0]              raddr_i,
  input  logic                       byp_en_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [XLEN-1:0]            wdata_i,
  output logic [XLEN-1:0]            rdata_o
);
  // byp_en_i already implies waddr_i != 0, so x0 never sees forwarded data
  assign rdata_o = (byp_en_i && (raddr_i == waddr_i)) ? wdata_i : regs_i[raddr_i];
endmodule

module core_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WVALID,
  input  logic [AW-1:0]        WADDR,
  input  logic [XLEN-1:0]      WDATA,
  input  logic [NRD*AW-1:0]    RADDR,
  output logic [NRD*XLEN-1:0]  RDATA,
  input  logic                 ISSUE_VALID,
  input  logic [AW-1:0]        ISSUE_ADDR,
  input  logic                 FLUSH,
  output logic [NREGS-1:0]     BUSY,
  input  logic                 CLR_REQ,
  output logic                 CLR_BUSY
);
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       idle, wr_en, iss_en, byp_en;

  assign idle   = (state_q == S_IDLE);
  assign wr_en  = idle && WVALID && (WADDR != '0);
  assign iss_en = idle && ISSUE_VALID && (ISSUE_ADDR != '0);
  assign byp_en = (BYPASS != 0) && wr_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (CLR_REQ) begin
        state_d = S_CLEAR;
        cnt_d   = AW'(1);
      end
      S_CLEAR: if (cnt_q == AW'(NREGS-1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + AW'(1);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[WADDR] = WDATA;
    if (!idle) regs_d[cnt_q] = '0;
    regs_d[0] = '0;
  end

  // issue is applied after the write clear so it wins a same-address collision;
  // flush is applied last so it overrides any issue
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[WADDR]      = 1'b0;
    if (iss_en) busy_d[ISSUE_ADDR] = 1'b1;
    if (!idle)  busy_d[cnt_q]      = 1'b0;
    if (FLUSH)  busy_d             = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      regs_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
    end
  end

  assign BUSY     = busy_q;
  assign CLR_BUSY = (state_q == S_CLEAR);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    core_regfile_sb_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rd (
      .regs_i   (regs_q),
      .raddr_i  (RADDR[k*AW +: AW]),
      .byp_en_i (byp_en),
      .waddr_i  (WADDR),
      .wdata_i  (WDATA),
      .rdata_o  (RDATA[k*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_core_regfile_sb.sv
// Directed bench: default configuration plus a 3-port/16-entry/64-bit
// instance without forwarding.

module tb_core_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance: XLEN=32 NREGS=32 NRD=2 BYPASS=1
  logic        a_wv, a_iv, a_fl, a_cr, a_cb;
  logic [4:0]  a_wa, a_ia;
  logic [31:0] a_wd, a_busy;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;

  // wide instance: XLEN=64 NREGS=16 NRD=3 BYPASS=0
  logic         b_wv, b_iv, b_fl, b_cr, b_cb;
  logic [3:0]   b_wa, b_ia;
  logic [63:0]  b_wd;
  logic [11:0]  b_ra;
  logic [191:0] b_rd;
  logic [15:0]  b_busy;

  core_regfile_sb u_a (
    .CLK(clk), .RST(rst), .WVALID(a_wv), .WADDR(a_wa), .WDATA(a_wd),
    .RADDR(a_ra), .RDATA(a_rd), .ISSUE_VALID(a_iv), .ISSUE_ADDR(a_ia),
    .FLUSH(a_fl), .BUSY(a_busy), .CLR_REQ(a_cr), .CLR_BUSY(a_cb)
  );

  core_regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(0)) u_b (
    .CLK(clk), .RST(rst), .WVALID(b_wv), .WADDR(b_wa), .WDATA(b_wd),
    .RADDR(b_ra), .RDATA(b_rd), .ISSUE_VALID(b_iv), .ISSUE_ADDR(b_ia),
    .FLUSH(b_fl), .BUSY(b_busy), .CLR_REQ(b_cr), .CLR_BUSY(b_cb)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cyc;

  initial begin
    rst = 1'b1;
    a_wv = 0; a_iv = 0; a_fl = 0; a_cr = 0; a_wa = 0; a_ia = 0; a_wd = 0; a_ra = 0;
    b_wv = 0; b_iv = 0; b_fl = 0; b_cr = 0; b_wa = 0; b_ia = 0; b_wd = 0; b_ra = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    a_ra = {5'd1, 5'd5}; #1;
    chk("rst_clr_busy", a_cb, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_r5", a_rd[31:0], 0);

    // write r5 with same-cycle forwarding, then registered value
    a_wv = 1; a_wa = 5; a_wd = 32'hDEADBEEF; #1;
    chk("byp_r5", a_rd[31:0], 32'hDEADBEEF);
    tick(); a_wv = 0; a_wd = 0; #1;
    chk("reg_r5", a_rd[31:0], 32'hDEADBEEF);

    // x0 ignores writes and issues
    a_ra = {5'd0, 5'd5};
    a_wv = 1; a_wa = 0; a_wd = 32'h12345678; a_iv = 1; a_ia = 0; #1;
    chk("x0_byp", a_rd[63:32], 0);
    tick(); a_wv = 0; a_iv = 0; #1;
    chk("x0_read", a_rd[63:32], 0);
    chk("x0_busy", a_busy, 0);

    // issue/write collision on r7: issue wins
    a_iv = 1; a_ia = 7; tick();
    a_wv = 1; a_wa = 7; a_wd = 32'h77; tick();
    a_iv = 0; a_wv = 0; a_ra = {5'd0, 5'd7}; #1;
    chk("coll_busy", a_busy, 32'h0000_0080);
    chk("coll_r7", a_rd[31:0], 32'h77);

    // a lone write clears r7; flush beats a same-cycle issue
    a_wv = 1; a_wa = 7; a_wd = 32'h78; tick(); a_wv = 0;
    chk("wr_clr_busy", a_busy, 0);
    a_iv = 1; a_ia = 9; tick();
    chk("iss_r9", a_busy, 32'h0000_0200);
    a_ia = 3; a_fl = 1; tick(); a_iv = 0; a_fl = 0;
    chk("flush", a_busy, 0);

    // fill every register and mark every register pending
    for (int i = 1; i < 32; i++) begin
      a_wv = 1; a_wa = 5'(i); a_wd = 32'h0101_0101 * i;
      a_iv = 1; a_ia = 5'(i);
      tick();
    end
    a_wv = 0; a_iv = 0;
    a_ra = {5'd1, 5'd31}; #1;
    chk("fill_busy", a_busy, 32'hFFFF_FFFE);
    chk("fill_r31", a_rd[31:0], 32'h1F1F_1F1F);
    chk("fill_r1", a_rd[63:32], 32'h0101_0101);

    // sweep; first CLEAR cycle tries a write, an issue and a new request
    a_cr = 1; tick(); a_cr = 0;
    a_wv = 1; a_wa = 31; a_wd = 32'hAAAA_AAAA; a_iv = 1; a_ia = 1; a_cr = 1; #1;
    chk("swp_cb", a_cb, 1);
    chk("swp_nobyp", a_rd[31:0], 32'h1F1F_1F1F);
    cyc = 1;
    tick(); a_wv = 0; a_iv = 0; a_cr = 0;
    chk("swp_r31_unswept", a_rd[31:0], 32'h1F1F_1F1F);
    chk("swp_r1_swept", a_rd[63:32], 0);
    chk("swp_busy_mid", a_busy, 32'hFFFF_FFFC);
    while (a_cb && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("swp_cycles", cyc, 31);
    chk("swp_busy_end", a_busy, 0);
    chk("swp_cb_end", a_cb, 0);
    begin
      int nz = 0;
      for (int i = 0; i < 32; i++) begin
        a_ra = {5'd0, 5'(i)}; #1;
        if (a_rd[31:0] != 0) nz++;
        tick();
      end
      chk("swp_all_zero", nz, 0);
    end

    // reset in sweep cycle 10, with a write and issue in the same cycle
    a_wv = 1; a_wa = 31; a_wd = 32'h31; tick();
    a_wa = 5; a_wd = 32'h55; tick();
    a_wv = 0; a_iv = 1; a_ia = 9; tick(); a_iv = 0;
    a_cr = 1; tick(); a_cr = 0;
    for (int i = 1; i < 10; i++) tick();
    rst = 1; a_wv = 1; a_wa = 20; a_wd = 32'h1; a_iv = 1; a_ia = 20; #1;
    chk("rst10_cb_pre", a_cb, 1);
    tick(); rst = 0; a_wv = 0; a_iv = 0; a_ra = {5'd20, 5'd31}; #1;
    chk("rst10_cb", a_cb, 0);
    chk("rst10_busy", a_busy, 0);
    chk("rst10_r31", a_rd[31:0], 0);
    chk("rst10_r20", a_rd[63:32], 0);
    a_wv = 1; a_wa = 12; a_wd = 32'hC0FFEE; tick(); a_wv = 0;
    a_ra = {5'd5, 5'd12}; #1;
    chk("rst10_wr", a_rd[31:0], 32'hC0FFEE);
    chk("rst10_r5", a_rd[63:32], 0);

    // wide instance: no forwarding, value visible the cycle after the edge
    b_ra = {4'd0, 4'd3, 4'd0};
    b_wv = 1; b_wa = 3; b_wd = 64'h1111_2222_3333_4444; #1;
    chk("b_nobyp", b_rd[127:64], 0);
    tick(); b_wv = 0; #1;
    chk("b_after", b_rd[127:64], 64'h1111_2222_3333_4444);
    b_wv = 1; b_wa = 9;  b_wd = 64'h9999_0000_0000_0009; tick();
    b_wa = 15; b_wd = 64'hFFFF_0000_0000_000F; tick(); b_wv = 0;
    b_ra = {4'd9, 4'd3, 4'd15}; #1;
    chk("b_p0", b_rd[63:0],    64'hFFFF_0000_0000_000F);
    chk("b_p1", b_rd[127:64],  64'h1111_2222_3333_4444);
    chk("b_p2", b_rd[191:128], 64'h9999_0000_0000_0009);
    b_cr = 1; tick(); b_cr = 0;
    cyc = 0;
    while (b_cb && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("b_swp_cycles", cyc, 15);
    chk("b_swp_p0", b_rd[63:0], 0);
    chk("b_swp_p2", b_rd[191:128], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_regfile_sb.md
CORE_REGFILE_SB -- requirements
Module: core_regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register.
REQ-002 Parameter NREGS, default 32: register count; power of two, at least 2.
REQ-003 Parameter NRD, default 2: number of read ports, at least 1.
REQ-004 Parameter BYPASS, default 1: 1 forwards same-cycle write data to reads; 0 gives no forwarding.
REQ-005 Localparam AW = $clog2(NREGS): address width.
REQ-006 CLK  in  1  single clock; all state updates on its rising edge.
REQ-007 RST  in  1  reset; synchronous, active-high.
REQ-008 WVALID  in  1  write strobe.
REQ-009 WADDR  in  AW  write address.
REQ-010 WDATA  in  XLEN  write data.
REQ-011 RADDR  in  NRD*AW  read addresses, flat; port k occupies bits [k*AW +: AW].
REQ-012 RDATA  out  NRD*XLEN  read data, flat; port k occupies bits [k*XLEN +: XLEN].
REQ-013 ISSUE_VALID  in  1  marks a destination register as pending.
REQ-014 ISSUE_ADDR  in  AW  destination register to mark.
REQ-015 FLUSH  in  1  clears all pending marks.
REQ-016 BUSY  out  NREGS  pending-write scoreboard, one bit per register.
REQ-017 CLR_REQ  in  1  requests a sequential zeroing of the register array.
REQ-018 CLR_BUSY  out  1  high while a zeroing sweep is in progress.

Function
REQ-019 Register 0 SHALL read as zero at all times, ignore writes, and have BUSY[0] fixed at 0.
REQ-020 A write with WVALID=1 and WADDR!=0 SHALL update the register at the next CLK edge, except while in state CLEAR.
REQ-021 Reads SHALL be combinational: RDATA port k equals the current contents of the register at RADDR port k.
REQ-022 When BYPASS=1, state is IDLE, WVALID=1 and WADDR==RADDR[k]!=0, RDATA port k SHALL equal WDATA in the same cycle.
REQ-023 When BYPASS=0, a written value SHALL first be visible on reads in the cycle after the write edge.
REQ-024 ISSUE_VALID=1 with ISSUE_ADDR!=0 SHALL set BUSY[ISSUE_ADDR] at the next edge.
REQ-025 An accepted write SHALL clear BUSY[WADDR] at the next edge.
REQ-026 If an issue and a write target the same address in the same cycle, the issue SHALL win and the bit ends set.
REQ-027 FLUSH=1 SHALL clear all BUSY bits at the next edge and SHALL override any same-cycle ISSUE_VALID.
REQ-028 The block SHALL implement a two-state machine:
- IDLE to CLEAR when CLR_REQ=1;
- in CLEAR, sweep counter CNT SHALL start at 1;
- each cycle in CLEAR, regs[CNT] SHALL be set to 0, BUSY[CNT] SHALL be cleared, and CNT SHALL increment;
- after writing NREGS-1, the machine SHALL return to IDLE.
REQ-029 A sweep SHALL therefore last exactly NREGS-1 cycles, with CLR_BUSY=1 for exactly those cycles.
REQ-030 In CLEAR, the block SHALL ignore WVALID, ISSUE_VALID and CLR_REQ, and SHALL disable bypass.
REQ-031 In CLEAR, FLUSH SHALL still apply.
REQ-032 In CLEAR, reads SHALL return the current array contents, whether swept or not yet swept.
REQ-033 CNT SHALL be AW bits wide and SHALL never wrap to 0 during a sweep.

Reset
REQ-034 With RST=1 at a CLK edge, the block SHALL take, at that edge, regardless of state or mid-sweep position:
- all registers = 0;
- BUSY = 0;
- state = IDLE;
- CNT = 0;
- CLR_BUSY = 0.
REQ-035 RST SHALL take priority over every other input in the same cycle.
REQ-036 The first write, issue or CLR_REQ SHALL be accepted at the first edge with RST=0.

Verification
REQ-037 Write: write 0xDEADBEEF to r5 with BYPASS=1 and RADDR0=5 in the same cycle -> RDATA0=0xDEADBEEF that cycle and the next.
REQ-038 x0: write 0x12345678 to r0 -> RDATA of r0 reads 0 and BUSY[0]=0.
REQ-039 Scoreboard, issue/write collision: issue r7, then one cycle later issue r7 and write r7 in the same cycle -> BUSY[7]=1.
REQ-040 Scoreboard, flush: continuing REQ-039, a further write r7 -> BUSY[7]=0; then issue r3 together with FLUSH -> BUSY=0.
REQ-041 Sweep, NREGS=32: all registers hold nonzero values, pulse CLR_REQ -> CLR_BUSY high for 31 cycles; a WVALID during the sweep has no effect; afterwards every register reads 0.
REQ-042 Reset mid-sweep: assert RST at sweep cycle 10 -> next cycle CLR_BUSY=0, BUSY=0, all registers 0, and a write in the following cycle succeeds.
REQ-043 Parameter check: NRD=3, NREGS=16, XLEN=64 -> three independent ports read distinct registers correctly, and a sweep lasts 15 cycles.
